// File: rtl/sync_fifo_pkg.sv
// Shared defaults and read-mode encoding for the synchronous FIFO family.
package sync_fifo_pkg;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AF_LEVEL   = 12;
  localparam int DEF_AE_LEVEL   = 4;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;
endpackage

// File: rtl/fifo_mem_2p.sv
// WIDTH x 2**ADDR_WIDTH storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem_2p #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered-read or first-word-fall-through output, status and sticky error flags.
// Full rejects put and empty rejects get; rejected requests raise overflow/underflow until cleared.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  put,
  input  logic                  get,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      data_out,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   fillcount,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam bit USE_FWFT = (FWFT == int'(FWFT_ON));

  if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH || AE_LEVEL < 0 || ADDR_WIDTH < 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_bad_params
    $error("param_sync_fifo: illegal parameter combination");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_accept, rd_accept;

  // Extra pointer MSB lets full and empty share equal low bits without ambiguity.
  assign fillcount    = wr_ptr - rd_ptr;
  assign empty        = (fillcount == '0);
  assign full         = (fillcount == DEPTH_C);
  assign almost_full  = (fillcount >= AF_C);
  assign almost_empty = (fillcount <= AE_C);

  assign wr_accept = put && !full;
  assign rd_accept = get && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
      // A fresh error in the clearing cycle must survive the clear.
      if (clear_err)     overflow  <= 1'b0;
      if (put && full)   overflow  <= 1'b1;
      if (clear_err)     underflow <= 1'b0;
      if (get && empty)  underflow <= 1'b1;
    end
  end

  fifo_mem_2p #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (USE_FWFT) begin : g_fwft
    // Stale memory is masked so nothing unwritten leaks out after reset.
    assign valid    = !empty;
    assign data_out = empty ? '0 : mem_rdata;
  end else begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_accept;
        if (rd_accept) data_q <= mem_rdata;
      end
    end

    assign valid    = valid_q;
    assign data_out = data_q;
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed plus random stimulus on registered-read and FWFT instances, checked against a queue model.
module tb_param_sync_fifo;
  logic       clk = 1'b0;
  logic       reset, put, get, clear_err;
  logic [7:0] data_in;

  logic [7:0] d0_data;
  logic       d0_valid, d0_empty, d0_full, d0_ae, d0_af, d0_ovf, d0_unf;
  logic [4:0] d0_fill;
  logic [7:0] f1_data;
  logic       f1_valid, f1_empty, f1_full, f1_ae, f1_af, f1_ovf, f1_unf;
  logic [4:0] f1_fill;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_vld;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  param_sync_fifo #(.FWFT(0)) dut_reg (
    .clk(clk), .reset(reset), .data_in(data_in), .put(put), .get(get), .clear_err(clear_err),
    .data_out(d0_data), .valid(d0_valid), .fillcount(d0_fill), .empty(d0_empty), .full(d0_full),
    .almost_empty(d0_ae), .almost_full(d0_af), .overflow(d0_ovf), .underflow(d0_unf)
  );

  param_sync_fifo #(.FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .data_in(data_in), .put(put), .get(get), .clear_err(clear_err),
    .data_out(f1_data), .valid(f1_valid), .fillcount(f1_fill), .empty(f1_empty), .full(f1_full),
    .almost_empty(f1_ae), .almost_full(f1_af), .overflow(f1_ovf), .underflow(f1_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string where);
    int cnt;
    cnt = q.size();
    chk({where, ":fill"},  32'(d0_fill), 32'(cnt));
    chk({where, ":empty"}, 32'(d0_empty), 32'(cnt == 0));
    chk({where, ":full"},  32'(d0_full), 32'(cnt == 16));
    chk({where, ":ae"},    32'(d0_ae), 32'(cnt <= 4));
    chk({where, ":af"},    32'(d0_af), 32'(cnt >= 12));
    chk({where, ":ovf"},   32'(d0_ovf), 32'(m_ovf));
    chk({where, ":unf"},   32'(d0_unf), 32'(m_unf));
    chk({where, ":vld0"},  32'(d0_valid), 32'(m_vld));
    chk({where, ":dout0"}, 32'(d0_data), 32'(m_dout));
    chk({where, ":fill1"}, 32'(f1_fill), 32'(cnt));
    chk({where, ":ovf1"},  32'(f1_ovf), 32'(m_ovf));
    chk({where, ":vld1"},  32'(f1_valid), 32'(cnt != 0));
    if (cnt != 0) chk({where, ":dout1"}, 32'(f1_data), 32'(q[0]));
  endtask

  // One clock with the given requests; the model applies the same edge, then outputs are compared.
  task automatic step(input string where, input logic p, input logic g, input logic c,
                      input logic [7:0] d);
    bit was_full, was_empty;
    logic [7:0] rd;
    put = p; get = g; clear_err = c; data_in = d;
    @(posedge clk);
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    m_vld = 1'b0;
    if (g && !was_empty) begin
      rd = q.pop_front();
      m_dout = rd;
      m_vld = 1'b1;
    end
    if (p && !was_full) q.push_back(d);
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (p && was_full) m_ovf = 1'b1;
    if (g && was_empty) m_unf = 1'b1;
    #1;
    compare_all(where);
  endtask

  task automatic do_reset(input string where);
    reset = 1'b1; put = 1'b1; get = 1'b1; clear_err = 1'b1; data_in = 8'hEE;
    @(posedge clk);
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0; m_dout = 8'h00;
    #1;
    compare_all(where);
    chk({where, ":dout1_rst"}, 32'(f1_data), 32'h0);
    reset = 1'b0; put = 1'b0; get = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; put = 1'b0; get = 1'b0; clear_err = 1'b0; data_in = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0; m_dout = 8'h00;
    @(posedge clk);
    do_reset("reset");

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
    step("overflow", 1'b1, 1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    step("underflow", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("hold_0f", 32'(d0_data), 32'h0F);
    step("clear", 1'b0, 1'b0, 1'b1, 8'h00);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step("wrap_put", 1'b1, 1'b0, 1'b0, 8'(8'h40 + r * 16 + i));
      for (int i = 0; i < 10; i++) step("wrap_get", 1'b0, 1'b1, 1'b0, 8'h00);
    end

    for (int i = 0; i < 5; i++) step("to5", 1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    step("pg_at5", 1'b1, 1'b1, 1'b0, 8'h5A);
    for (int i = 0; i < 5; i++) step("to0", 1'b0, 1'b1, 1'b0, 8'h00);
    step("pg_at0", 1'b1, 1'b1, 1'b0, 8'h60);
    for (int i = 0; i < 15; i++) step("to16", 1'b1, 1'b0, 1'b0, 8'(8'h61 + i));
    step("pg_at16", 1'b1, 1'b1, 1'b0, 8'h99);
    chk("pg16_ovf", 32'(d0_ovf), 32'h1);

    do_reset("reset2");
    step("fwft_put", 1'b1, 1'b0, 1'b0, 8'hA5);
    chk("fwft_a5", 32'(f1_data), 32'hA5);
    step("fwft_get", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) step("pre7", 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    step("pre7_ovf", 1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 9; i++) step("to7", 1'b0, 1'b1, 1'b0, 8'h00);
    do_reset("reset_mid");
    step("post_rst_put", 1'b1, 1'b0, 1'b0, 8'h3C);
    step("post_rst_get", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step("refill", 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    step("clr_vs_ovf", 1'b1, 1'b0, 1'b1, 8'hFF);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rnd_reset");
      else step("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 19) == 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
